// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read DMA: fetches a word-aligned block in 1 KiB-safe bursts and
// streams the words out through an internal FIFO.
//
// Ports:
//   i_wire_clock, i_wire_reset        clock, synchronous active-high reset
//   i_wire_start/address/length       transfer request (bytes / words)
//   o_wire_data, o_wire_data_valid    FIFO head word and not-empty flag
//   i_wire_data_next                  consumer pop
//   o_wire_done, o_wire_error(_type)  completion and error status
//   o_wire_m_axi_ar*, i_wire_m_axi_arready   AXI read address channel
//   i_wire_m_axi_r*,  o_wire_m_axi_rready    AXI read data channel
module painterengine_gpu_dma_reader #(
    parameter int PARAM_FIFO_DEPTH = 16
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_reset,
    input  logic        i_wire_start,
    input  logic [31:0] i_wire_address,
    input  logic [31:0] i_wire_length,
    output logic [31:0] o_wire_data,
    output logic        o_wire_data_valid,
    input  logic        i_wire_data_next,
    output logic        o_wire_done,
    output logic        o_wire_error,
    output logic [2:0]  o_wire_error_type,
    output logic [0:0]  o_wire_m_axi_arid,
    output logic [31:0] o_wire_m_axi_araddr,
    output logic [7:0]  o_wire_m_axi_arlen,
    output logic [2:0]  o_wire_m_axi_arsize,
    output logic [1:0]  o_wire_m_axi_arburst,
    output logic        o_wire_m_axi_arlock,
    output logic [3:0]  o_wire_m_axi_arcache,
    output logic [2:0]  o_wire_m_axi_arprot,
    output logic [3:0]  o_wire_m_axi_arqos,
    output logic        o_wire_m_axi_arvalid,
    input  logic        i_wire_m_axi_arready,
    input  logic [0:0]  i_wire_m_axi_rid,
    input  logic [31:0] i_wire_m_axi_rdata,
    input  logic [1:0]  i_wire_m_axi_rresp,
    input  logic        i_wire_m_axi_rlast,
    input  logic        i_wire_m_axi_rvalid,
    output logic        o_wire_m_axi_rready
);

    localparam int LP_PW = $clog2(PARAM_FIFO_DEPTH);
    localparam logic [LP_PW:0] LP_FULL = (LP_PW + 1)'(PARAM_FIFO_DEPTH);

    typedef enum logic [4:0] {
        S_IDLE       = 5'h01,
        S_CHECK      = 5'h02,
        S_CALC       = 5'h03,
        S_ADDR       = 5'h04,
        S_DATA       = 5'h05,
        S_DRAIN      = 5'h06,
        S_DONE       = 5'h07,
        S_ALIGN_ERR  = 5'h11,
        S_LEN_ERR    = 5'h12,
        S_AR_TIMEOUT = 5'h13,
        S_RRESP_ERR  = 5'h14,
        S_RLAST_ERR  = 5'h15
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [31:0]      r_address;
    logic [31:0]      r_length;
    logic [31:0]      r_offset;
    logic [8:0]       r_burstlen;
    logic [8:0]       r_beat;
    logic [7:0]       r_timeout;
    logic [31:0]      r_araddr;
    logic [7:0]       r_arlen;
    logic [31:0]      r_mem [PARAM_FIFO_DEPTH];
    logic [LP_PW-1:0] r_wptr;
    logic [LP_PW-1:0] r_rptr;
    logic [LP_PW:0]   r_count;

    logic        w_start_ok;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_last;
    logic [2:0]  w_error_type;
    logic [7:0]  w_word;
    logic [8:0]  w_room;
    logic [31:0] w_remain;
    logic [8:0]  w_burstlen;
    logic [31:0] w_off_sum;
    logic        w_unused;

    assign w_start_ok = i_wire_start &&
        (r_state == S_IDLE || r_state == S_DONE || r_state[4]);
    assign w_full   = (r_count == LP_FULL);
    assign w_pop    = (r_count != '0) && i_wire_data_next;
    assign w_last   = (r_beat == r_burstlen - 9'd1);
    assign w_off_sum = r_offset + {23'd0, r_burstlen};

    // Word index inside the current 1 KiB page bounds the burst length.
    assign w_word     = r_address[9:2] + r_offset[7:0];
    assign w_room     = 9'd256 - {1'b0, w_word};
    assign w_remain   = r_length - r_offset;
    assign w_burstlen = (w_remain < {23'd0, w_room}) ? w_remain[8:0] : w_room;

    assign w_unused = ^i_wire_m_axi_rid;

    always_comb begin
        w_next    = r_state;
        w_arvalid = 1'b0;
        w_rready  = 1'b0;
        w_push    = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: ;
            S_CHECK: begin
                if (r_address[1:0] != 2'b00)
                    w_next = S_ALIGN_ERR;
                else if (r_length == 32'd0)
                    w_next = S_LEN_ERR;
                else
                    w_next = S_CALC;
            end
            S_CALC: w_next = S_ADDR;
            S_ADDR: begin
                w_arvalid = 1'b1;
                if (i_wire_m_axi_arready)
                    w_next = S_DATA;
                else if (r_timeout == 8'd255)
                    w_next = S_AR_TIMEOUT;
            end
            S_DATA: begin
                w_rready = !w_full;
                if (i_wire_m_axi_rvalid && w_rready) begin
                    if (i_wire_m_axi_rresp > 2'b01)
                        w_next = S_RRESP_ERR;
                    else if (i_wire_m_axi_rlast != w_last)
                        w_next = S_RLAST_ERR;
                    else begin
                        w_push = 1'b1;
                        if (w_last)
                            w_next = (w_off_sum >= r_length) ? S_DRAIN : S_CALC;
                    end
                end
            end
            S_DRAIN: if (r_count == '0) w_next = S_DONE;
            S_ALIGN_ERR, S_LEN_ERR, S_AR_TIMEOUT,
            S_RRESP_ERR, S_RLAST_ERR: ;
            default: w_next = S_IDLE;
        endcase
        if (w_start_ok)
            w_next = S_CHECK;
    end

    always_comb begin
        w_error_type = 3'd0;
        unique case (r_state)
            S_ALIGN_ERR:  w_error_type = 3'd1;
            S_LEN_ERR:    w_error_type = 3'd2;
            S_AR_TIMEOUT: w_error_type = 3'd3;
            S_RRESP_ERR:  w_error_type = 3'd4;
            S_RLAST_ERR:  w_error_type = 3'd5;
            default:      w_error_type = 3'd0;
        endcase
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge i_wire_clock) begin
        if (i_wire_reset) begin
            r_address  <= '0;
            r_length   <= '0;
            r_offset   <= '0;
            r_burstlen <= '0;
            r_beat     <= '0;
            r_timeout  <= '0;
            r_araddr   <= '0;
            r_arlen    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (w_start_ok) begin
            r_address <= i_wire_address;
            r_length  <= i_wire_length;
            r_offset  <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            if (r_state == S_CALC) begin
                r_burstlen <= w_burstlen;
                r_araddr   <= r_address + {r_offset[29:0], 2'b00};
                r_arlen    <= w_burstlen[7:0] - 8'd1;
                r_timeout  <= '0;
            end
            if (r_state == S_ADDR) begin
                if (i_wire_m_axi_arready)
                    r_beat <= '0;
                else
                    r_timeout <= r_timeout + 8'd1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
                r_beat <= r_beat + 9'd1;
                if (w_last)
                    r_offset <= w_off_sum;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge i_wire_clock) begin
        if (w_push)
            r_mem[r_wptr] <= i_wire_m_axi_rdata;
    end

    assign o_wire_data       = r_mem[r_rptr];
    assign o_wire_data_valid = (r_count != '0);
    assign o_wire_done       = (r_state == S_DONE);
    assign o_wire_error      = r_state[4];
    assign o_wire_error_type = w_error_type;

    assign o_wire_m_axi_arid    = 1'b0;
    assign o_wire_m_axi_araddr  = r_araddr;
    assign o_wire_m_axi_arlen   = r_arlen;
    assign o_wire_m_axi_arsize  = 3'b010;
    assign o_wire_m_axi_arburst = 2'b01;
    assign o_wire_m_axi_arlock  = 1'b0;
    assign o_wire_m_axi_arcache = 4'b0010;
    assign o_wire_m_axi_arprot  = 3'b000;
    assign o_wire_m_axi_arqos   = 4'b0000;
    assign o_wire_m_axi_arvalid = w_arvalid;
    assign o_wire_m_axi_rready  = w_rready;

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for painterengine_gpu_dma_reader: AXI slave, consumer and
// transfer-level reference model.
module tb_painterengine_gpu_dma_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] addr_i;
    logic [31:0] len_i;
    logic [31:0] data;
    logic        data_valid;
    logic        s_next;
    logic        done;
    logic        error;
    logic [2:0]  error_type;
    logic [0:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  arqos;
    logic        arvalid;
    logic        s_arready;
    logic [0:0]  s_rid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rlast;
    logic        s_rvalid;
    logic        rready;

    always #5 clk = ~clk;

    painterengine_gpu_dma_reader #(.PARAM_FIFO_DEPTH(16)) dut (
        .i_wire_clock(clk),
        .i_wire_reset(rst),
        .i_wire_start(start),
        .i_wire_address(addr_i),
        .i_wire_length(len_i),
        .o_wire_data(data),
        .o_wire_data_valid(data_valid),
        .i_wire_data_next(s_next),
        .o_wire_done(done),
        .o_wire_error(error),
        .o_wire_error_type(error_type),
        .o_wire_m_axi_arid(arid),
        .o_wire_m_axi_araddr(araddr),
        .o_wire_m_axi_arlen(arlen),
        .o_wire_m_axi_arsize(arsize),
        .o_wire_m_axi_arburst(arburst),
        .o_wire_m_axi_arlock(arlock),
        .o_wire_m_axi_arcache(arcache),
        .o_wire_m_axi_arprot(arprot),
        .o_wire_m_axi_arqos(arqos),
        .o_wire_m_axi_arvalid(arvalid),
        .i_wire_m_axi_arready(s_arready),
        .i_wire_m_axi_rid(s_rid),
        .i_wire_m_axi_rdata(s_rdata),
        .i_wire_m_axi_rresp(s_rresp),
        .i_wire_m_axi_rlast(s_rlast),
        .i_wire_m_axi_rvalid(s_rvalid),
        .o_wire_m_axi_rready(rready)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    int ar_mode = 0;
    int rv_mode = 0;
    int cons_mode = 0;
    int rresp_err = -1;
    int rlast_flip = -1;
    int cur_beat = 0;
    int beat_total = 0;
    int arv_cycles = 0;

    logic [31:0] q_addr[$];
    int          q_len[$];
    logic [31:0] seen_addr[$];
    int          seen_len[$];
    logic [31:0] got_q[$];
    logic [31:0] ra;
    int          rl;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AXI slave and consumer: inputs change on the falling edge, and the
    // handshakes that the next rising edge will see are booked here.
    initial begin
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        s_rlast = 0; s_rid = 0; s_next = 0;
        forever begin
            @(negedge clk);
            s_arready = (ar_mode == 0) ||
                        (ar_mode == 1 && $urandom_range(0, 1) == 1);
            if (q_addr.size() > 0) begin
                s_rvalid = (rv_mode == 0) || ($urandom_range(0, 1) == 1);
                s_rdata  = mem_word(q_addr[0] + 32'(4 * cur_beat));
                s_rlast  = (cur_beat == q_len[0]) ^ (beat_total == rlast_flip);
                s_rresp  = (beat_total == rresp_err) ? 2'b10 : 2'b00;
            end else begin
                s_rvalid = 0; s_rdata = 0; s_rlast = 0; s_rresp = 0;
            end
            s_next = (cons_mode == 0) ||
                     (cons_mode == 1 && $urandom_range(0, 1) == 1);
            #1;
            if (rst) begin
                q_addr.delete(); q_len.delete(); cur_beat = 0;
            end else begin
                if (arvalid) arv_cycles++;
                if (s_rvalid && rready) begin
                    beat_total++;
                    if (cur_beat == q_len[0]) begin
                        void'(q_addr.pop_front());
                        void'(q_len.pop_front());
                        cur_beat = 0;
                    end else cur_beat++;
                end
                if (arvalid && s_arready) begin
                    seen_addr.push_back(araddr); seen_len.push_back(int'(arlen));
                    q_addr.push_back(araddr); q_len.push_back(int'(arlen));
                end
                if (data_valid && s_next) got_q.push_back(data);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
    endtask

    task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
        @(negedge clk);
        seen_addr.delete(); seen_len.delete(); got_q.delete();
        arv_cycles = 0; beat_total = 0;
        addr_i = a; len_i = l; start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_end(input int budget, input string tag);
        int i;
        i = 0;
        while (!(done || error) && i < budget) begin
            @(negedge clk); i++;
        end
        check({tag, "_finished"}, 32'(done || error), 1);
    endtask

    // Reference: split into bursts that stop at each 1 KiB page end.
    task automatic check_xfer(input logic [31:0] a, input int len,
                              input string tag);
        logic [31:0] ea[$];
        int el[$];
        int off, room, bl, n, bad;
        logic [31:0] cur;
        off = 0;
        while (off < len) begin
            cur  = a + 32'(4 * off);
            room = int'(((cur / 1024) + 1) * 1024 - cur) / 4;
            bl   = (len - off < room) ? len - off : room;
            ea.push_back(cur); el.push_back(bl - 1);
            off += bl;
        end
        check({tag, "_nbursts"}, seen_addr.size(), ea.size());
        n = (seen_addr.size() < ea.size()) ? seen_addr.size() : ea.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_araddr"}, seen_addr[i], ea[i]);
            check({tag, "_arlen"}, seen_len[i], el[i]);
        end
        check({tag, "_nwords"}, got_q.size(), len);
        n = (got_q.size() < len) ? got_q.size() : len;
        bad = 0;
        for (int i = 0; i < n; i++)
            if (got_q[i] !== mem_word(a + 32'(4 * i))) bad++;
        check({tag, "_bad_words"}, bad, 0);
    endtask

    initial begin
        rst = 1; start = 0; addr_i = 0; len_i = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_etype", error_type, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_araddr", araddr, 0);
        check("rst_arlen", arlen, 0);
        check("rst_valid", data_valid, 0);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);
        check("arcache", arcache, 4'b0010);
        check("ar_zero", {arid, arlock, arprot, arqos}, 0);

        start_xfer(32'h1000, 4);
        wait_end(200, "basic");
        check("basic_done", done, 1);
        check_xfer(32'h1000, 4, "basic");

        start_xfer(32'h13F8, 5);
        wait_end(200, "split");
        check("split_done", done, 1);
        check("split_first", seen_addr.size() > 0 ? seen_addr[0] : 0, 32'h13F8);
        check_xfer(32'h13F8, 5, "split");

        start_xfer(32'h1002, 4);
        wait_end(50, "align");
        check("align_error", error, 1);
        check("align_etype", error_type, 1);
        check("align_noar", arv_cycles, 0);
        start_xfer(32'h1000, 0);
        wait_end(50, "len0");
        check("len0_etype", error_type, 2);

        cons_mode = 2;
        start_xfer(32'h2000, 40);
        repeat (60) @(negedge clk);
        check("full_rready", rready, 0);
        check("full_beats", beat_total, 16);
        check("full_valid", data_valid, 1);
        cons_mode = 0;
        wait_end(500, "full");
        check("full_done", done, 1);
        check_xfer(32'h2000, 40, "full");

        ar_mode = 1; rv_mode = 1; cons_mode = 1;
        for (int t = 0; t < 6; t++) begin
            ra = 32'h0001_0000 + 32'($urandom_range(0, 1023)) * 4;
            rl = $urandom_range(1, 300);
            start_xfer(ra, 32'(rl));
            wait_end(8000, "rand");
            check("rand_done", done, 1);
            check_xfer(ra, rl, "rand");
        end
        ar_mode = 0; rv_mode = 0; cons_mode = 0;

        rresp_err = 2;
        start_xfer(32'h5000, 8);
        wait_end(200, "rresp");
        repeat (5) @(negedge clk);
        check("rresp_etype", error_type, 4);
        check("rresp_words", got_q.size(), 2);
        rresp_err = -1;
        do_reset();

        rlast_flip = 1;
        start_xfer(32'h5100, 4);
        wait_end(200, "rlast");
        check("rlast_etype", error_type, 5);
        rlast_flip = -1;
        do_reset();

        ar_mode = 2;
        start_xfer(32'h6000, 4);
        wait_end(400, "tmo");
        check("tmo_etype", error_type, 3);
        check("tmo_cycles", arv_cycles, 256);
        check("tmo_arvalid", arvalid, 0);
        ar_mode = 0;
        do_reset();

        rv_mode = 1; cons_mode = 1;
        start_xfer(32'h4000, 100);
        repeat (30) @(negedge clk);
        do_reset();
        check("mid_valid", data_valid, 0);
        check("mid_arvalid", arvalid, 0);
        check("mid_rready", rready, 0);
        check("mid_araddr", araddr, 0);
        check("mid_arlen", arlen, 0);
        check("mid_status", {done, error, error_type}, 0);
        start_xfer(32'h7000, 20);
        wait_end(1000, "after");
        check("after_done", done, 1);
        check_xfer(32'h7000, 20, "after");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
